// File: rtl/alu_seq_pkg.sv
// +--------------------------------------------------------------------+
// | alu_seq_pkg                                                        |
// | Opcode, FSM state and flag-index definitions shared by alu_seq.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_LSH = 4'd5,
        OP_RSH = 4'd6,
        OP_SEQ = 4'd7,
        OP_SNE = 4'd8,
        OP_SLT = 4'd9,
        OP_MUL = 4'd10,
        OP_ASR = 4'd11,
        OP_NOP = 4'd12
    } op_mne;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// +--------------------------------------------------------------------+
// | alu_mul_iter                                                       |
// | Radix-2 shift-add multiplier, W cycles from start to done.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_mul_iter #(
    parameter int W = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           done,
    output logic [2*W-1:0] product
);
    import alu_seq_pkg::*;

    localparam int c_CW = $clog2(W);

    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [c_CW-1:0] r_cnt;
    logic           r_busy;

    // The first partial product is folded into the load, leaving W-1 steps.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= B[0] ? {{W{1'b0}}, A} : '0;
            r_mcand  <= {{W{1'b0}}, A} << 1;
            r_mplier <= B >> 1;
            r_cnt    <= c_CW'(W - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done    = r_busy && (r_cnt == '0);
    assign product = r_acc;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------+
// | alu_seq                                                            |
// | Registered ALU with valid/ready handshake, flags and iterative MUL.|
// | Optional ADD/SUB saturation when ALU_SAT_EN is defined.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq #(
    parameter int W   = 8,
    parameter int OPS = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           In_valid,
    output logic           In_ready,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [OPS-1:0] OP,
    output logic           Out_valid,
    input  logic           Out_ready,
    output logic [W-1:0]   Out,
    output logic [3:0]     Flags
);
    import alu_seq_pkg::*;

    localparam logic [W-1:0] c_SH_MAX = W'(W);

    alu_state_t     r_state;
    alu_state_t     w_state_nxt;
    logic [W-1:0]   r_out;
    logic [3:0]     r_flags;

    op_mne          w_op;
    logic           w_op_hi;
    logic           w_accept;
    logic           w_load_alu;
    logic           w_load_mul;
    logic           w_mul_start;
    logic           w_mul_done;
    logic [2*W-1:0] w_product;

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W:0]     w_lsh;
    logic [W:0]     w_rsh;
    logic signed [W:0] w_asr;
    logic [W-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic [3:0]     w_flags;
    logic [3:0]     w_mul_flags;

    generate
        if (OPS > 4) begin : g_op_hi
            assign w_op_hi = |OP[OPS-1:4];
        end else begin : g_op_narrow
            assign w_op_hi = 1'b0;
        end
    endgenerate

    always_comb begin
        w_op = OP_NOP;
        if (!w_op_hi && (OP[3:0] < 4'd12)) begin
            w_op = op_mne'(OP[3:0]);
        end
    end

    assign In_ready  = Reset_n && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && Out_ready));
    assign Out_valid = (r_state == ST_HOLD);
    assign w_accept  = In_valid && In_ready;

    // Shifts run on W+1 bits so the last bit shifted out lands in a fixed slot.
    assign w_sum  = {1'b0, InputA} + {1'b0, InputB};
    assign w_diff = {1'b0, InputA} - {1'b0, InputB};
    assign w_lsh  = {1'b0, InputA} << InputB;
    assign w_rsh  = {InputA, 1'b0} >> InputB;
    assign w_asr  = $signed({InputA, 1'b0}) >>> InputB;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (InputA[W-1] == InputB[W-1]) && (w_sum[W-1] != InputA[W-1]);
`ifdef ALU_SAT_EN
                if (w_sum[W]) begin
                    w_res = '1;
                    w_v   = 1'b1;
                end
`endif
            end
            OP_SUB: begin
                w_res = w_diff[W-1:0];
                w_c   = ~w_diff[W];
                w_v   = (InputA[W-1] != InputB[W-1]) && (w_diff[W-1] != InputA[W-1]);
`ifdef ALU_SAT_EN
                if (w_diff[W]) begin
                    w_res = '0;
                    w_v   = 1'b1;
                end
`endif
            end
            OP_AND: w_res = InputA & InputB;
            OP_OR:  w_res = InputA | InputB;
            OP_XOR: w_res = {{(W-1){1'b0}}, ^InputB};
            OP_LSH: begin
                w_res = w_lsh[W-1:0];
                w_c   = w_lsh[W];
            end
            OP_RSH: begin
                w_res = w_rsh[W:1];
                w_c   = w_rsh[0];
            end
            OP_ASR: begin
                w_res = w_asr[W:1];
                w_c   = (InputB > c_SH_MAX) ? 1'b0 : w_asr[0];
            end
            OP_SEQ: w_res = {{(W-1){1'b0}}, (InputA == InputB)};
            OP_SNE: w_res = {{(W-1){1'b0}}, (InputA != InputB)};
            OP_SLT: w_res = {{(W-1){1'b0}}, (InputA < InputB)};
            default: w_res = '0;
        endcase
        w_flags         = '0;
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_N] = w_res[W-1];
        w_flags[FLAG_V] = w_v;
    end

    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_Z] = (w_product[W-1:0] == '0);
        w_mul_flags[FLAG_C] = |w_product[2*W-1:W];
        w_mul_flags[FLAG_N] = w_product[W-1];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = ST_HOLD;
                    w_load_mul  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (Out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // An accept overrides the HOLD->IDLE drain, giving back-to-back results.
        if (w_accept) begin
            if (w_op == OP_MUL) begin
                w_state_nxt = ST_MUL;
                w_mul_start = 1'b1;
            end else begin
                w_state_nxt = ST_HOLD;
                w_load_alu  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_alu) begin
                r_out   <= w_res;
                r_flags <= w_flags;
            end else if (w_load_mul) begin
                r_out   <= w_product[W-1:0];
                r_flags <= w_mul_flags;
            end
        end
    end

    assign Out   = r_out;
    assign Flags = r_flags;

    alu_mul_iter #(
        .W (W)
    ) u_mul (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (w_mul_start),
        .A       (InputA),
        .B       (InputB),
        .done    (w_mul_done),
        .product (w_product)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------+
// | tb_alu_seq                                                         |
// | Scoreboard bench for alu_seq: reference model, latency, backpressure|
// | and reset-during-MUL checks.                                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

    localparam int W   = 8;
    localparam int OPS = 4;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           In_valid;
    logic           In_ready;
    logic [W-1:0]   InputA;
    logic [W-1:0]   InputB;
    logic [OPS-1:0] OP;
    logic           Out_valid;
    logic           Out_ready;
    logic [W-1:0]   Out;
    logic [3:0]     Flags;

    int             checks   = 0;
    int             failures = 0;
    logic [W+3:0]   sb[$];
    logic [W+3:0]   mon_exp;

    always #5 Clk = ~Clk;

    alu_seq #(
        .W   (W),
        .OPS (OPS)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .InputA    (InputA),
        .InputB    (InputB),
        .OP        (OP),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out       (Out),
        .Flags     (Flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model in integer arithmetic; returns {Z,C,N,V,result}.
    function automatic logic [W+3:0] model(input int op, input longint a, input longint b);
        longint full = longint'(1) << W;
        longint half = full / 2;
        longint sa, sbv, s, r;
        logic [W-1:0] rv;
        bit c = 0, v = 0, z, n;
        sa  = (a >= half) ? a - full : a;
        sbv = (b >= half) ? b - full : b;
        r   = 0;
        case (op)
            0: begin
                s = a + b; c = (s >= full); r = s % full;
                v = ((sa + sbv) >= half) || ((sa + sbv) < -half);
`ifdef ALU_SAT_EN
                if (c) begin r = full - 1; v = 1; end
`endif
            end
            1: begin
                c = (a >= b); r = (a - b + full) % full;
                v = ((sa - sbv) >= half) || ((sa - sbv) < -half);
`ifdef ALU_SAT_EN
                if (!c) begin r = 0; v = 1; end
`endif
            end
            2: r = a & b;
            3: r = a | b;
            4: for (int i = 0; i < W; i++) r = r ^ ((b >> i) & 1);
            5: begin
                if (b == 0) r = a;
                else if (b <= W) begin r = (a << b) % full; c = ((a >> (W - b)) & 1) == 1; end
                else r = 0;
            end
            6: begin
                if (b == 0) r = a;
                else if (b <= W) begin r = a >> b; c = ((a >> (b - 1)) & 1) == 1; end
                else r = 0;
            end
            7: r = (a == b) ? 1 : 0;
            8: r = (a != b) ? 1 : 0;
            9: r = (a < b) ? 1 : 0;
            10: begin s = a * b; r = s % full; c = (s / full) != 0; end
            11: begin
                if (b == 0) r = a;
                else if (b < W) begin
                    r = sa >>> b;
                    if (r < 0) r = r + full;
                    c = ((a >> (b - 1)) & 1) == 1;
                end else begin
                    r = (sa < 0) ? full - 1 : 0;
                    c = (b == W) && (sa < 0);
                end
            end
            default: r = 0;
        endcase
        rv = r[W-1:0];
        z  = (rv == '0);
        n  = rv[W-1];
        return {z, c, n, v, rv};
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n) begin
            sb.delete();
        end else begin
            if (Out_valid && Out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'(sb.size()), 1);
                end else begin
                    mon_exp = sb.pop_front();
                    check("sb_out", 32'(Out), 32'(mon_exp[W-1:0]));
                    check("sb_flags", 32'(Flags), 32'(mon_exp[W+3:W]));
                end
            end
            if (In_valid && In_ready) begin
                sb.push_back(model(int'(OP), longint'(InputA), longint'(InputB)));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int op, input int a, input int b);
        int n = 0;
        OP       = OPS'(op);
        InputA   = W'(a);
        InputB   = W'(b);
        In_valid = 1'b1;
        @(negedge Clk);
        while (!In_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        check("send_ready", 32'(In_ready), 1);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
    endtask

    initial begin
        int n;
        Reset_n   = 1'b0;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        InputA    = '0;
        InputB    = '0;
        OP        = '0;
        repeat (2) @(negedge Clk);
        check("rst_out_valid", 32'(Out_valid), 0);
        check("rst_out", 32'(Out), 0);
        check("rst_flags", 32'(Flags), 0);
        check("rst_in_ready", 32'(In_ready), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_in_ready", 32'(In_ready), 1);
        @(posedge Clk);
        #1;

        send(0, 'hFF, 'h01);
        check("add_lat_valid", 32'(Out_valid), 1);
`ifdef ALU_SAT_EN
        check("add_wrap_out", 32'(Out), 'hFF);
        check("add_wrap_flags", 32'(Flags), 4'b0111);
`else
        check("add_wrap_out", 32'(Out), 'h00);
        check("add_wrap_flags", 32'(Flags), 4'b1100);
`endif
        send(1, 'h03, 'h05);
        send(9, 'h03, 'h05);
        send(11, 'h90, 2);
        send(11, 'h90, 9);
        send(11, 'h90, 8);
        send(5, 'h81, 1);
        send(5, 'h81, 8);
        send(5, 'h81, 9);
        send(6, 'h81, 8);
        send(6, 'h81, 0);
        send(4, 'h00, 'h07);
        send(2, 'hF0, 'h3C);
        send(3, 'hF0, 'h0C);
        send(7, 'h55, 'h55);
        send(8, 'h55, 'h55);
        send(0, 'h7F, 'h01);
        send(1, 'h80, 'h01);
        send(13, 'h12, 'h34);

        send(10, 'h10, 'h11);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check("mul_busy_ready", 32'(In_ready), 0);
            check("mul_busy_valid", 32'(Out_valid), 0);
        end
        @(negedge Clk);
        check("mul_lat_valid", 32'(Out_valid), 1);
        check("mul_out", 32'(Out), 'h10);
        check("mul_flags", 32'(Flags), 4'b0100);
        @(posedge Clk);
        #1;
        send(10, 'h0F, 'h0F);
        repeat (12) @(posedge Clk);
        #1;

        Out_ready = 1'b0;
        send(0, 'h12, 'h34);
        OP       = 4'd1;
        InputA   = 'h50;
        InputB   = 'h20;
        In_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_out", 32'(Out), 'h46);
            check("bp_flags", 32'(Flags), 0);
            check("bp_valid", 32'(Out_valid), 1);
            check("bp_in_ready", 32'(In_ready), 0);
        end
        @(posedge Clk);
        #1;
        Out_ready = 1'b1;
        @(negedge Clk);
        check("bp_release_ready", 32'(In_ready), 1);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        @(negedge Clk);
        check("bp_nogap_valid", 32'(Out_valid), 1);
        check("bp_nogap_out", 32'(Out), 'h30);
        @(posedge Clk);
        #1;

        send(10, 'h10, 'h11);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(Out_valid), 0);
        check("rst_mid_out", 32'(Out), 0);
        check("rst_mid_flags", 32'(Flags), 0);
        check("rst_mid_ready", 32'(In_ready), 0);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post_rst_valid", 32'(Out_valid), 0);
        @(posedge Clk);
        #1;
        send(0, 2, 3);
        check("post_rst_add", 32'(Out), 'h05);

        for (int i = 0; i < 30; i++) begin
            int op;
            int b;
            op = int'($urandom_range(0, 15));
            b  = ((op == 5) || (op == 6) || (op == 11)) ? int'($urandom_range(0, 11))
                                                        : int'($urandom_range(0, 255));
            send(op, int'($urandom_range(0, 255)), b);
        end

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            n++;
            @(negedge Clk);
        end
        check("sb_drain", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
